// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a boot-load port streams words in from
// index 0 upward, and a registered fetch port serves byte-addressed reads
// once the image is complete. Fetches are refused until a load has finished.
module instr_mem_loadable #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,  // 32 or 64
  parameter int DEPTH      = (2 ** ADDR_WIDTH) / (DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  load_done_o,
  output logic [ADDR_WIDTH-1:0] load_words_o,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  misaligned_o
);

  localparam int WB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(WB);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_ptr;

  logic                  load_acc;   // load word written this cycle
  logic                  load_end;   // accepted word closes the image
  logic                  fetch_acc;  // fetch accepted this cycle
  logic                  fetch_mis;  // fetch address not word aligned
  logic [IDX_W-1:0]      fetch_idx;

  assign load_acc  = load_valid_i & load_ready_o;
  // The final slot ends the image even without load_last_i, so the pointer
  // never wraps onto words already written.
  assign load_end  = load_last_i | (wr_ptr == IDX_W'(DEPTH - 1));
  assign fetch_acc = fetch_req_i & fetch_ready_o;
  assign fetch_idx = fetch_addr_i[ADDR_WIDTH-1:OFF_W];
  assign fetch_mis = |fetch_addr_i[OFF_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic: a start pulse always (re)enters LOAD.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      EMPTY: if (load_start_i) state_nxt = LOAD;
      LOAD: begin
        if (load_start_i)              state_nxt = LOAD;
        else if (load_acc && load_end) state_nxt = READY;
      end
      READY: if (load_start_i) state_nxt = LOAD;
      default: state_nxt = EMPTY;
    endcase
  end

  // Port-ready outputs; a start pulse blocks both ports for that cycle.
  always_comb begin
    load_ready_o  = 1'b0;
    fetch_ready_o = 1'b0;
    case (state)
      LOAD:    load_ready_o  = !load_start_i;
      READY:   fetch_ready_o = !load_start_i;
      default: ;
    endcase
  end

  // Load bookkeeping: write pointer, word count and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      load_words_o <= '0;
      load_done_o  <= 1'b0;
    end else begin
      load_done_o <= load_acc & load_end;
      if (load_start_i) begin
        wr_ptr       <= '0;
        load_words_o <= '0;
      end else if (load_acc) begin
        wr_ptr       <= wr_ptr + IDX_W'(1);
        load_words_o <= load_words_o + ADDR_WIDTH'(1);
      end
    end
  end

  // Storage write; a reset edge abandons the word presented in that cycle.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; contents survive rst and map to RAM.
    if (!rst && load_acc) mem[wr_ptr] <= load_data_i;
  end

  // Registered fetch response; instruction_o holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_o <= 1'b0;
      misaligned_o  <= 1'b0;
      instruction_o <= '0;
    end else begin
      instr_valid_o <= fetch_acc;
      misaligned_o  <= fetch_acc & fetch_mis;
      if (fetch_acc) instruction_o <= fetch_mis ? '0 : mem[fetch_idx];
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed scenarios on a
// default-size instance, a capacity scenario on a 4-word instance, and a
// randomized load/fetch phase checked against an array-based model.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;

  // Default instance (ADDR_WIDTH=10, 256 words).
  logic        load_start, load_valid, load_last, fetch_req;
  logic [31:0] load_data;
  logic [9:0]  fetch_addr;
  logic        load_ready, load_done, fetch_ready, instr_valid, misaligned;
  logic [9:0]  load_words;
  logic [31:0] instruction;

  // Small instance (ADDR_WIDTH=4, 4 words).
  logic        s_load_start, s_load_valid, s_load_last, s_fetch_req;
  logic [31:0] s_load_data;
  logic [3:0]  s_fetch_addr;
  logic        s_load_ready, s_load_done, s_fetch_ready, s_instr_valid, s_misaligned;
  logic [3:0]  s_load_words;
  logic [31:0] s_instruction;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state for the randomized phase.
  logic [31:0] ref_mem [256];
  int          known;
  logic [31:0] last_instr;

  instr_mem_loadable dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start), .load_valid_i(load_valid),
    .load_data_i(load_data), .load_last_i(load_last),
    .load_ready_o(load_ready), .load_done_o(load_done),
    .load_words_o(load_words),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_ready_o(fetch_ready), .instr_valid_o(instr_valid),
    .instruction_o(instruction), .misaligned_o(misaligned)
  );

  instr_mem_loadable #(.ADDR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst),
    .load_start_i(s_load_start), .load_valid_i(s_load_valid),
    .load_data_i(s_load_data), .load_last_i(s_load_last),
    .load_ready_o(s_load_ready), .load_done_o(s_load_done),
    .load_words_o(s_load_words),
    .fetch_req_i(s_fetch_req), .fetch_addr_i(s_fetch_addr),
    .fetch_ready_o(s_fetch_ready), .instr_valid_o(s_instr_valid),
    .instruction_o(s_instruction), .misaligned_o(s_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    settle();
    check("start_blocks_load_ready", load_ready, 0);
    check("start_blocks_fetch_ready", fetch_ready, 0);
    cycle();
    load_start = 1'b0;
  endtask

  // Present one load word for one cycle and check the count/pulse after it.
  task automatic load_word(input logic [31:0] d, input bit last,
                           input bit exp_done, input int exp_words);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    settle();
    check("load_ready_in_load", load_ready, 1);
    cycle();
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_done", load_done, exp_done);
    check("load_words", load_words, exp_words);
  endtask

  // One accepted fetch, checked one cycle later.
  task automatic fetch(input logic [9:0] a, input logic [31:0] exp_instr,
                       input bit exp_mis);
    fetch_req  = 1'b1;
    fetch_addr = a;
    settle();
    check("fetch_ready", fetch_ready, 1);
    cycle();
    fetch_req = 1'b0;
    check("instr_valid", instr_valid, 1);
    check("misaligned", misaligned, exp_mis);
    check("instruction", instruction, exp_instr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_words"}, load_words, 0);
    check({tag, "_fetch_ready"}, fetch_ready, 0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instruction"}, instruction, 0);
    check({tag, "_misaligned"}, misaligned, 0);
  endtask

  initial begin
    logic [31:0] img [3];
    logic [31:0] ga, gb, gc;

    rst = 1'b1;
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_req = 0; fetch_addr = '0;
    s_load_start = 0; s_load_valid = 0; s_load_last = 0; s_load_data = '0;
    s_fetch_req = 0; s_fetch_addr = '0;
    cycle();
    cycle();
    rst = 1'b0;
    check_all_zero("reset");

    // EMPTY refuses fetches.
    fetch_req = 1'b1;
    fetch_addr = '0;
    settle();
    check("empty_fetch_ready", fetch_ready, 0);
    cycle();
    check("empty_instr_valid", instr_valid, 0);
    cycle();
    check("empty_instr_valid2", instr_valid, 0);
    fetch_req = 1'b0;

    // Three-word program, then back-to-back fetches.
    img[0] = 32'h0050_0093;
    img[1] = 32'h0010_8113;
    img[2] = 32'hFFDF_F06F;
    start_load();
    load_word(img[0], 0, 0, 1);
    load_word(img[1], 0, 0, 2);
    load_word(img[2], 1, 1, 3);
    fetch_req = 1'b1; fetch_addr = 10'h000; settle();
    check("b2b_ready0", fetch_ready, 1);
    cycle();
    check("b2b_done_clears", load_done, 0);
    check("b2b_valid0", instr_valid, 1);
    check("b2b_instr0", instruction, img[0]);
    fetch_addr = 10'h004; settle();
    check("b2b_ready1", fetch_ready, 1);
    cycle();
    check("b2b_valid1", instr_valid, 1);
    check("b2b_instr1", instruction, img[1]);
    fetch_addr = 10'h008; settle();
    cycle();
    fetch_req = 1'b0;
    check("b2b_valid2", instr_valid, 1);
    check("b2b_instr2", instruction, img[2]);
    cycle();
    check("idle_valid", instr_valid, 0);
    check("idle_holds_instr", instruction, img[2]);

    // Misaligned fetch, then idle.
    fetch(10'h006, 32'h0, 1);
    cycle();
    check("mis_idle_valid", instr_valid, 0);
    check("mis_idle_misaligned", misaligned, 0);

    // Load with a gap; the idle cycle carries junk and a stray last flag.
    ga = 32'hA5A5_0001; gb = 32'hB6B6_0002; gc = 32'hC7C7_0003;
    start_load();
    check("restart_words_zero", load_words, 0);
    load_word(ga, 0, 0, 1);
    load_data = 32'hDEAD_BEEF; load_last = 1'b1;
    cycle();
    load_last = 1'b0;
    check("gap_done", load_done, 0);
    check("gap_words", load_words, 1);
    load_word(gb, 0, 0, 2);
    load_word(gc, 1, 1, 3);
    fetch(10'h000, ga, 0);
    fetch(10'h004, gb, 0);
    fetch(10'h008, gc, 0);

    // Capacity on the 4-word instance: six words, no last flag.
    s_load_start = 1'b1;
    cycle();
    s_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = 32'h0000_0100 + 32'(i);
      settle();
      check("cap_load_ready", s_load_ready, (i < 4));
      cycle();
      check("cap_load_done", s_load_done, (i == 3));
      check("cap_load_words", s_load_words, (i < 4) ? i + 1 : 4);
    end
    s_load_valid = 1'b0;
    s_fetch_req = 1'b1; s_fetch_addr = 4'h0; settle();
    check("cap_fetch_ready", s_fetch_ready, 1);
    cycle();
    check("cap_valid0", s_instr_valid, 1);
    check("cap_word0", s_instruction, 32'h0000_0100);
    s_fetch_addr = 4'hC;
    cycle();
    s_fetch_req = 1'b0;
    check("cap_word3", s_instruction, 32'h0000_0103);

    // In-flight fetch survives a start pulse; start wins over a fetch.
    fetch_req = 1'b1; fetch_addr = 10'h004;
    cycle();
    load_start = 1'b1; fetch_addr = 10'h000;
    settle();
    check("inflight_valid", instr_valid, 1);
    check("inflight_instr", instruction, gb);
    check("start_wins_fetch_ready", fetch_ready, 0);
    check("start_load_ready", load_ready, 0);
    cycle();
    load_start = 1'b0;
    settle();
    check("start_no_response", instr_valid, 0);
    check("load_state_fetch_ready", fetch_ready, 0);
    check("load_state_load_ready", load_ready, 1);
    fetch_req = 1'b0;
    load_word(32'h1111_2222, 0, 0, 1);

    // Reset mid-load, with a word presented on the reset edge.
    rst = 1'b1; load_valid = 1'b1; load_data = 32'h3333_4444;
    cycle();
    rst = 1'b0; load_valid = 1'b0;
    check_all_zero("midload_reset");
    load_valid = 1'b1; load_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("empty_ignores_load", load_ready, 0);
      cycle();
      check("empty_no_done", load_done, 0);
      check("empty_words", load_words, 0);
    end
    load_valid = 1'b0; load_last = 1'b0;

    // Memory survives reset: reload one word, index 1 still holds gb.
    start_load();
    load_word(32'h5555_6666, 1, 1, 1);
    fetch(10'h004, gb, 0);
    fetch(10'h000, 32'h5555_6666, 0);

    // Randomized loads and fetches against the array model.
    known = 0;
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 12);
      start_load();
      for (int i = 0; i < n; i++) begin
        logic [31:0] d;
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          load_data = $urandom;
          load_last = 1'($urandom);
          settle();
          check("rnd_gap_ready", load_ready, 1);
          cycle();
          load_last = 1'b0;
          check("rnd_gap_done", load_done, 0);
          check("rnd_gap_words", load_words, i);
        end
        d = $urandom;
        ref_mem[i] = d;
        load_word(d, (i == n - 1), (i == n - 1), i + 1);
      end
      if (n > known) known = n;
      for (int j = 0; j < 16; j++) begin
        bit          req;
        int          idx;
        int          off;
        logic [31:0] exp_i;
        req = (j == 0) || ($urandom_range(0, 3) != 0);
        idx = $urandom_range(0, known - 1);
        off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        fetch_req  = req;
        fetch_addr = 10'(idx * 4 + off);
        settle();
        check("rnd_fetch_ready", fetch_ready, 1);
        cycle();
        if (req) begin
          exp_i = (off != 0) ? 32'h0 : ref_mem[idx];
          last_instr = exp_i;
        end
        check("rnd_done_low", load_done, 0);
        check("rnd_valid", instr_valid, req);
        check("rnd_misaligned", misaligned, req && (off != 0));
        check("rnd_instruction", instruction, last_instr);
      end
      fetch_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
